// File: rtl/cache_axi_arbiter_pkg.sv
// Shared encodings for the cache-to-AXI arbiter: AXI constants, default IDs,
// read grant FSM states and the round-robin grant marker.
package cache_axi_arbiter_pkg;

    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [3:0] INST_ID_DEFAULT = 4'd0;
    localparam logic [3:0] DATA_ID_DEFAULT = 4'd1;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_INST = 2'b01,
        R_DATA = 2'b10
    } rd_state_t;

    typedef enum logic {
        GRANT_INST = 1'b0,
        GRANT_DATA = 1'b1
    } grant_t;

endpackage

// File: rtl/cache_axi_arbiter.sv
// Merges i-cache reads and d-cache reads/writes onto one AXI4 master port.
// Reads are serialised one burst at a time; writes pass straight through.
module cache_axi_arbiter
    import cache_axi_arbiter_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter logic [3:0] INST_ID    = INST_ID_DEFAULT,
    parameter logic [3:0] DATA_ID    = DATA_ID_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   inst_araddr,
    input  logic [7:0]              inst_arlen,
    input  logic                    inst_arvalid,
    output logic                    inst_arready,
    output logic [DATA_WIDTH-1:0]   inst_rdata,
    output logic                    inst_rlast,
    output logic                    inst_rvalid,
    input  logic                    inst_rready,

    input  logic [ADDR_WIDTH-1:0]   data_araddr,
    input  logic [7:0]              data_arlen,
    input  logic                    data_arvalid,
    output logic                    data_arready,
    output logic [DATA_WIDTH-1:0]   data_rdata,
    output logic                    data_rlast,
    output logic                    data_rvalid,
    input  logic                    data_rready,

    input  logic [ADDR_WIDTH-1:0]   data_awaddr,
    input  logic [7:0]              data_awlen,
    input  logic                    data_awvalid,
    output logic                    data_awready,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    input  logic [DATA_WIDTH/8-1:0] data_wstrb,
    input  logic                    data_wlast,
    input  logic                    data_wvalid,
    output logic                    data_wready,
    output logic                    data_bvalid,
    input  logic                    data_bready,

    output logic [3:0]              m_arid,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [3:0]              m_rid,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic                    m_rvalid,
    output logic                    m_rready,

    output logic [3:0]              m_awid,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [3:0]              m_wid,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [3:0]              m_bid,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready
);

    rd_state_t state;
    grant_t    last_grant;
    logic      ar_done;
    logic      wr_busy;

    logic data_ok;
    logic ar_fire;
    logic r_last_fire;
    logic aw_fire;
    logic b_fire;
    logic unused_resp;

    assign unused_resp = ^{m_rresp, m_bresp, m_bid};

    // A pending or in-flight d-cache write blocks d-cache reads so a refill never overtakes its writeback.
    assign data_ok     = data_arvalid & ~wr_busy & ~data_awvalid;
    assign ar_fire     = m_arvalid & m_arready;
    assign r_last_fire = m_rvalid & m_rready & m_rlast;
    assign aw_fire     = m_awvalid & m_awready;
    assign b_fire      = m_bvalid & m_bready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= R_IDLE;
            last_grant <= GRANT_INST;
            ar_done    <= 1'b0;
            wr_busy    <= 1'b0;
        end else begin
            if (aw_fire)
                wr_busy <= 1'b1;
            else if (b_fire)
                wr_busy <= 1'b0;

            case (state)
                R_IDLE: begin
                    if (data_ok && (!inst_arvalid || last_grant == GRANT_INST)) begin
                        state      <= R_DATA;
                        last_grant <= GRANT_DATA;
                    end else if (inst_arvalid) begin
                        state      <= R_INST;
                        last_grant <= GRANT_INST;
                    end
                end
                R_INST, R_DATA: begin
                    if (ar_fire)
                        ar_done <= 1'b1;
                    if (r_last_fire) begin
                        state   <= R_IDLE;
                        ar_done <= 1'b0;
                    end
                end
                default: begin
                    state   <= R_IDLE;
                    ar_done <= 1'b0;
                end
            endcase
        end
    end

    // Address and data channels follow the granted client; the other client sees nothing.
    always_comb begin
        m_arid       = '0;
        m_araddr     = '0;
        m_arlen      = '0;
        m_arvalid    = 1'b0;
        inst_arready = 1'b0;
        data_arready = 1'b0;
        inst_rvalid  = 1'b0;
        inst_rdata   = '0;
        inst_rlast   = 1'b0;
        data_rvalid  = 1'b0;
        data_rdata   = '0;
        data_rlast   = 1'b0;
        m_rready     = 1'b0;
        case (state)
            R_INST: begin
                m_arid       = INST_ID;
                m_araddr     = inst_araddr;
                m_arlen      = inst_arlen;
                m_arvalid    = inst_arvalid & ~ar_done;
                inst_arready = m_arready & ~ar_done;
                if (ar_done) begin
                    inst_rvalid = m_rvalid;
                    inst_rdata  = m_rdata;
                    inst_rlast  = m_rlast;
                    m_rready    = inst_rready;
                end
            end
            R_DATA: begin
                m_arid       = DATA_ID;
                m_araddr     = data_araddr;
                m_arlen      = data_arlen;
                m_arvalid    = data_arvalid & ~ar_done;
                data_arready = m_arready & ~ar_done;
                if (ar_done) begin
                    data_rvalid = m_rvalid;
                    data_rdata  = m_rdata;
                    data_rlast  = m_rlast;
                    m_rready    = data_rready;
                end
            end
            default: ;
        endcase
    end

    assign m_arsize     = AXI_SIZE_4B;
    assign m_arburst    = AXI_BURST_INCR;

    assign m_awid       = DATA_ID;
    assign m_awaddr     = data_awaddr;
    assign m_awlen      = data_awlen;
    assign m_awsize     = AXI_SIZE_4B;
    assign m_awburst    = AXI_BURST_INCR;
    assign m_awvalid    = data_awvalid;
    assign data_awready = m_awready;
    assign m_wid        = DATA_ID;
    assign m_wdata      = data_wdata;
    assign m_wstrb      = data_wstrb;
    assign m_wlast      = data_wlast;
    assign m_wvalid     = data_wvalid;
    assign data_wready  = m_wready;
    assign data_bvalid  = m_bvalid;
    assign m_bready     = data_bready;

    rid_matches_grant: assert property (@(posedge clk) disable iff (rst)
        (m_rvalid && state != R_IDLE) |-> (m_rid == ((state == R_INST) ? INST_ID : DATA_ID)));

endmodule
